// File: rtl/sipo_pkg.sv
// Shared helpers for the serial-in/parallel-out deserializer.
package sipo_pkg;

  // Ceiling log2; returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Number of lane beats that make up one word
  function automatic int unsigned beats_of(input int unsigned lane_w, input int unsigned word_w);
    return word_w / lane_w;
  endfunction

  // Width of a beat count able to hold 0..BEATS
  function automatic int unsigned cw_of(input int unsigned lane_w, input int unsigned word_w);
    return clog2(beats_of(lane_w, word_w) + 1);
  endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry valid/ready holding register for assembled words.
module sipo_out_slot #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CW     = 4
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              load_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [CW-1:0]     beats_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [WORD_W-1:0] data_o,
  output logic [CW-1:0]     beats_o
);

  // Load wins over drain so a word can be replaced in the same edge it is taken
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      beats_o <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      beats_o <= beats_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser_hs.sv
// Lane-serial to word-parallel deserializer with valid/ready on both sides and partial flush.
module sipo_deser_hs
  import sipo_pkg::*;
#(
  parameter int unsigned LANE_W       = 1,
  parameter int unsigned WORD_W       = 8,
  parameter bit          SHIFT_IN_LSB = 1'b1,
  localparam int unsigned BEATS       = beats_of(LANE_W, WORD_W),
  localparam int unsigned CW          = cw_of(LANE_W, WORD_W)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [LANE_W-1:0] in_data_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_data_o,
  output logic [CW-1:0]     out_beats_o
);

  if (LANE_W == 0 || (WORD_W % LANE_W) != 0 || BEATS < 2) begin : g_param_err
    $error("sipo_deser_hs: WORD_W must be a non-zero multiple of LANE_W with at least 2 beats");
  end

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  localparam logic [CW-1:0] FULL = CW'(BEATS);

  logic [WORD_W-1:0] asm_r, asm_d, shifted, load_data;
  logic [CW-1:0]     cnt_r, cnt_d, load_beats;
  logic              flush_pend_r, flush_pend_d;
  logic              slot_free, accept, complete, flush_go, load;

  // Beat insertion direction is fixed at elaboration
  if (SHIFT_IN_LSB) begin : g_lsb
    assign shifted = {asm_r[WORD_W-LANE_W-1:0], in_data_i};
  end else begin : g_msb
    assign shifted = {in_data_i, asm_r[WORD_W-1:LANE_W]};
  end

  // Ready depends combinationally on out_ready_i so full words never bubble
  assign slot_free  = !out_valid_o | out_ready_i;
  assign in_ready_o = reset_ni & !flush_pend_r & ((cnt_r < LAST) | slot_free);
  assign accept     = in_valid_i & in_ready_o;
  assign complete   = accept & (cnt_r == LAST);
  assign flush_go   = flush_i & ((cnt_r != '0) | accept);

  // Next-state for the assembler and slot load decision
  always_comb begin
    asm_d        = asm_r;
    cnt_d        = cnt_r;
    flush_pend_d = flush_pend_r;
    load         = 1'b0;
    load_data    = shifted;
    load_beats   = FULL;
    if (flush_pend_r) begin
      if (slot_free) begin
        load         = 1'b1;
        load_data    = asm_r;
        load_beats   = cnt_r;
        asm_d        = '0;
        cnt_d        = '0;
        flush_pend_d = 1'b0;
      end
    end else if (complete) begin
      load  = 1'b1;
      asm_d = '0;
      cnt_d = '0;
    end else if (flush_go) begin
      if (slot_free) begin
        load       = 1'b1;
        load_data  = accept ? shifted : asm_r;
        load_beats = cnt_r + CW'(accept);
        asm_d      = '0;
        cnt_d      = '0;
      end else begin
        flush_pend_d = 1'b1;
        if (accept) begin
          asm_d = shifted;
          cnt_d = cnt_r + CW'(1);
        end
      end
    end else if (accept) begin
      asm_d = shifted;
      cnt_d = cnt_r + CW'(1);
    end
  end

  // Assembler state registers
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      asm_r        <= '0;
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
    end else begin
      asm_r        <= asm_d;
      cnt_r        <= cnt_d;
      flush_pend_r <= flush_pend_d;
    end
  end

  sipo_out_slot #(
    .WORD_W (WORD_W),
    .CW     (CW)
  ) u_slot (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .load_i   (load),
    .data_i   (load_data),
    .beats_i  (load_beats),
    .ready_i  (out_ready_i),
    .valid_o  (out_valid_o),
    .data_o   (out_data_o),
    .beats_o  (out_beats_o)
  );

endmodule

// File: tb/tb_sipo_deser_hs.sv
// Directed bench: two instances (LSB-first and MSB-first insertion) share the same stimulus.
module tb_sipo_deser_hs;

  localparam int unsigned LANE_W = 2;
  localparam int unsigned WORD_W = 8;
  localparam int unsigned CW     = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic              reset_ni, in_valid_i, flush_i, out_ready_i;
  logic [LANE_W-1:0] in_data_i;
  logic              rdy_l, rdy_m, ov_l, ov_m;
  logic [WORD_W-1:0] d_l, d_m;
  logic [CW-1:0]     b_l, b_m;

  int total = 0;
  int bad   = 0;

  sipo_deser_hs #(.LANE_W(LANE_W), .WORD_W(WORD_W), .SHIFT_IN_LSB(1'b1)) u_lsb (
    .clk_i(clk_i), .reset_ni(reset_ni), .in_valid_i(in_valid_i), .in_ready_o(rdy_l),
    .in_data_i(in_data_i), .flush_i(flush_i), .out_valid_o(ov_l), .out_ready_i(out_ready_i),
    .out_data_o(d_l), .out_beats_o(b_l)
  );

  sipo_deser_hs #(.LANE_W(LANE_W), .WORD_W(WORD_W), .SHIFT_IN_LSB(1'b0)) u_msb (
    .clk_i(clk_i), .reset_ni(reset_ni), .in_valid_i(in_valid_i), .in_ready_o(rdy_m),
    .in_data_i(in_data_i), .flush_i(flush_i), .out_valid_o(ov_m), .out_ready_i(out_ready_i),
    .out_data_o(d_m), .out_beats_o(b_m)
  );

  typedef struct {
    logic       rst_n, iv;
    logic [1:0] d;
    logic       fl, ordy;
    logic       e_rdy, e_ov, cd;
    logic [7:0] e_l, e_m;
    logic [2:0] e_b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_n, iv, input logic [1:0] d, input logic fl, ordy,
                              input logic e_rdy, e_ov, cd, input logic [7:0] e_l, e_m,
                              input logic [2:0] e_b);
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.cd = cd; v.e_l = e_l; v.e_m = e_m; v.e_b = e_b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one row, check ready before the edge and registered outputs after it
  task automatic apply(input vec_t t, input int idx);
    reset_ni    = t.rst_n;
    in_valid_i  = t.iv;
    in_data_i   = t.d;
    flush_i     = t.fl;
    out_ready_i = t.ordy;
    #1;
    chk($sformatf("v%0d in_ready_lsb", idx), 32'(rdy_l), 32'(t.e_rdy));
    chk($sformatf("v%0d in_ready_msb", idx), 32'(rdy_m), 32'(t.e_rdy));
    @(posedge clk_i);
    #1;
    chk($sformatf("v%0d out_valid_lsb", idx), 32'(ov_l), 32'(t.e_ov));
    chk($sformatf("v%0d out_valid_msb", idx), 32'(ov_m), 32'(t.e_ov));
    if (t.cd) begin
      chk($sformatf("v%0d data_lsb", idx), 32'(d_l), 32'(t.e_l));
      chk($sformatf("v%0d data_msb", idx), 32'(d_m), 32'(t.e_m));
      chk($sformatf("v%0d beats_lsb", idx), 32'(b_l), 32'(t.e_b));
      chk($sformatf("v%0d beats_msb", idx), 32'(b_m), 32'(t.e_b));
    end
  endtask

  initial begin
    // rst iv d fl ordy | rdy ov cd lsb msb beats
    // reset and first idle cycle
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1, 8'h00, 8'h00, 0));
    // beats 3,2,1,0 with consumer ready
    tbl.push_back(mk(1, 1, 3, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1, 8'hE4, 8'h1B, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    // consumer stalled across 8 beats, then released
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1, 8'hE4, 8'h1B, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    // partial flush with a free slot
    tbl.push_back(mk(1, 1, 3, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 1, 8'h0E, 8'hB0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    // partial flush with the slot occupied: pends until the consumer drains
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 1, 1, 8'h0E, 8'hB0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    // reset mid-word with the slot full
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 3, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 2, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1, 8'h1B, 8'hE4, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 3, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1, 8'hE4, 8'h1B, 4));
    // flush with nothing assembled is ignored
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    // flush on the completing beat yields one full word only
    tbl.push_back(mk(1, 1, 3, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 2, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, 1, 8'hE4, 8'h1B, 4));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));
    // flush together with the first beat: one-beat word
    tbl.push_back(mk(1, 1, 2, 1, 1, 1, 1, 1, 8'h02, 8'h80, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0));

    reset_ni    = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    @(posedge clk_i);
    #1;

    foreach (tbl[i]) apply(tbl[i], i);

    // 16 back-to-back beats 0,1,2,3,...: ready never drops, each word valid one cycle
    begin
      int words_l;
      int words_m;
      words_l = 0;
      words_m = 0;
      for (int i = 0; i < 17; i++) begin
        in_valid_i  = (i < 16);
        in_data_i   = 2'(i);
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        #1;
        chk($sformatf("stream%0d in_ready_lsb", i), 32'(rdy_l), 32'd1);
        chk($sformatf("stream%0d in_ready_msb", i), 32'(rdy_m), 32'd1);
        @(posedge clk_i);
        #1;
        if (ov_l) words_l++;
        if (ov_m) words_m++;
        chk($sformatf("stream%0d out_valid", i), 32'(ov_l), 32'((i % 4 == 3) && (i < 16)));
        if (ov_l) begin
          chk($sformatf("stream%0d data_lsb", i), 32'(d_l), 32'h1B);
          chk($sformatf("stream%0d data_msb", i), 32'(d_m), 32'hE4);
          chk($sformatf("stream%0d beats", i), 32'(b_l), 32'd4);
        end
      end
      chk("stream word_count_lsb", 32'(words_l), 32'd4);
      chk("stream word_count_msb", 32'(words_m), 32'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
